// File: rtl/object_stats_reader.sv
// Walks labels 1..num_labels-1, reads per-label accumulators and emits integer centroids
// computed by a shared restoring divider. Optional minimum-area filter: OBJ_SIZE_FILTER_EN.
module object_stats_reader #(
    parameter int ACC_WIDTH  = 32,
    parameter int LOC_WIDTH  = 16,
    parameter int WORD_WIDTH = 8,
    parameter int MIN_AREA   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] num_labels,
    output logic [WORD_WIDTH-1:0] obj_id,
    input  logic [ACC_WIDTH-1:0]  area_in,
    input  logic [ACC_WIDTH-1:0]  x_acc_in,
    input  logic [ACC_WIDTH-1:0]  y_acc_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_id,
    output logic [LOC_WIDTH-1:0]  out_x,
    output logic [LOC_WIDTH-1:0]  out_y,
    output logic [ACC_WIDTH-1:0]  out_area,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam int CNT_W = $clog2(ACC_WIDTH);

    logic [2:0]            state_q, state_d;
    logic [WORD_WIDTH-1:0] obj_id_q, obj_id_d;
    logic [WORD_WIDTH-1:0] last_q, last_d;
    logic [ACC_WIDTH-1:0]  area_q, area_d;
    logic [ACC_WIDTH-1:0]  x_rem_q, x_rem_d, y_rem_q, y_rem_d;
    logic [ACC_WIDTH-1:0]  x_dvd_q, x_dvd_d, y_dvd_q, y_dvd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] out_id_q, out_id_d;
    logic [LOC_WIDTH-1:0]  out_x_q, out_x_d, out_y_q, out_y_d;
    logic [ACC_WIDTH-1:0]  out_area_q, out_area_d;
    logic [2*ACC_WIDTH-1:0] x_step, y_step;
    logic                   skip;
    logic                   is_last;

    // One restoring step: shift the next dividend bit into the (ACC_WIDTH+1)-bit partial
    // remainder; the quotient bit replaces the consumed dividend bit, so the dividend
    // register ends up holding the quotient. Returns {remainder, dividend/quotient}.
    function automatic logic [2*ACC_WIDTH-1:0] div_step(
        input logic [ACC_WIDTH-1:0] rem,
        input logic [ACC_WIDTH-1:0] dvd,
        input logic [ACC_WIDTH-1:0] divisor
    );
        logic [ACC_WIDTH:0]   part;
        logic                 ge;
        logic [ACC_WIDTH-1:0] rem_next;
        part     = {rem, dvd[ACC_WIDTH-1]};
        ge       = (part >= {1'b0, divisor});
        rem_next = ge ? (part[ACC_WIDTH-1:0] - divisor) : part[ACC_WIDTH-1:0];
        return {rem_next, dvd[ACC_WIDTH-2:0], ge};
    endfunction

    assign x_step  = div_step(x_rem_q, x_dvd_q, area_q);
    assign y_step  = div_step(y_rem_q, y_dvd_q, area_q);
    assign is_last = (obj_id_q == last_q);

`ifdef OBJ_SIZE_FILTER_EN
    assign skip = (area_q == '0) || (area_q < ACC_WIDTH'(MIN_AREA));
`else
    assign skip = (area_q == '0);
`endif

    // NOTE: every _d starts from its _q so that no path through the case leaves a latch.
    always_comb begin
        state_d    = state_q;
        obj_id_d   = obj_id_q;
        last_d     = last_q;
        area_d     = area_q;
        x_rem_d    = x_rem_q;
        y_rem_d    = y_rem_q;
        x_dvd_d    = x_dvd_q;
        y_dvd_d    = y_dvd_q;
        cnt_d      = cnt_q;
        out_id_d   = out_id_q;
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        out_area_d = out_area_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_d   = num_labels - WORD_WIDTH'(1);
                    obj_id_d = WORD_WIDTH'(1);
                    state_d  = (num_labels <= WORD_WIDTH'(1)) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                area_d  = area_in;
                x_dvd_d = x_acc_in;
                y_dvd_d = y_acc_in;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (skip) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        obj_id_d = obj_id_q + WORD_WIDTH'(1);
                        state_d  = S_READ;
                    end
                end else begin
                    x_rem_d = '0;
                    y_rem_d = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                x_rem_d = x_step[2*ACC_WIDTH-1:ACC_WIDTH];
                x_dvd_d = x_step[ACC_WIDTH-1:0];
                y_rem_d = y_step[2*ACC_WIDTH-1:ACC_WIDTH];
                y_dvd_d = y_step[ACC_WIDTH-1:0];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ACC_WIDTH - 1)) begin
                    out_id_d   = obj_id_q;
                    out_x_d    = x_step[LOC_WIDTH-1:0];
                    out_y_d    = y_step[LOC_WIDTH-1:0];
                    out_area_d = area_q;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        obj_id_d = obj_id_q + WORD_WIDTH'(1);
                        state_d  = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            obj_id_q   <= '0;
            last_q     <= '0;
            area_q     <= '0;
            x_rem_q    <= '0;
            y_rem_q    <= '0;
            x_dvd_q    <= '0;
            y_dvd_q    <= '0;
            cnt_q      <= '0;
            out_id_q   <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
            out_area_q <= '0;
        end else begin
            state_q    <= state_d;
            obj_id_q   <= obj_id_d;
            last_q     <= last_d;
            area_q     <= area_d;
            x_rem_q    <= x_rem_d;
            y_rem_q    <= y_rem_d;
            x_dvd_q    <= x_dvd_d;
            y_dvd_q    <= y_dvd_d;
            cnt_q      <= cnt_d;
            out_id_q   <= out_id_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
            out_area_q <= out_area_d;
        end
    end

    assign obj_id    = obj_id_q;
    assign out_id    = out_id_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_area  = out_area_q;
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: doc/object_stats_reader.md
# object_stats_reader

Reads back per-label feature accumulators (area, Σx·p, Σy·p) that the connected-components labeler writes into its data table. After a frame completes, it walks labels 1..num_labels-1 and computes each object's integer centroid with a shared sequential divider. It emits one record per object on a valid/ready stream toward the object-reporting logic. It drives the data table's second read port (`obj_id`) and replaces the combinational divide on that path.

## Interface
- `ACC_WIDTH`, 32: width of each accumulator (area, x_acc, y_acc) and of the divider.
- `LOC_WIDTH`, 16: width of reported centroid coordinates.
- `WORD_WIDTH`, 8: label width.
- `MIN_AREA`, 4: minimum reported area; used only with `OBJ_SIZE_FILTER_EN`.
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin a scan; sampled only in IDLE.
- `num_labels`, in, WORD_WIDTH: next free label from the labeler; sampled on accepted `start`.
- `obj_id`, out, WORD_WIDTH: data-table read address (registered).
- `area_in`, in, ACC_WIDTH: table read data, area field for `obj_id`.
- `x_acc_in`, in, ACC_WIDTH: table read data, Σx·p field for `obj_id`.
- `y_acc_in`, in, ACC_WIDTH: table read data, Σy·p field for `obj_id`.
- `out_valid`, out, 1: record valid.
- `out_ready`, in, 1: consumer accepts the record.
- `out_id`, out, WORD_WIDTH: label of the record.
- `out_x`, out, LOC_WIDTH: centroid x, `x_acc / area`, truncated.
- `out_y`, out, LOC_WIDTH: centroid y.
- `out_area`, out, ACC_WIDTH: object area.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse at the end of a scan.

## Operation
- Reset values: state IDLE; `obj_id` = 0, `out_*` = 0, `out_valid` = 0, `busy` = 0, `done` = 0.
- **IDLE**
  - On `start`, latch `last = num_labels - 1` and set `obj_id <= 1`.
  - If `num_labels <= 1`, go to DONE. Otherwise go to READ.
  - `start` outside IDLE is ignored.
- **READ** (1 cycle): table data for `obj_id` is valid this cycle. Register `area_in`, `x_acc_in` and `y_acc_in` at the clock edge. Go to CHECK.
- **CHECK** (1 cycle): skip the object if `area == 0`; also skip it if the filter is enabled and `area < MIN_AREA`.
  - On skip: if `obj_id == last`, go to DONE; otherwise `obj_id++` and go to READ.
  - Otherwise, initialize the divider and go to DIV.
- **DIV** (exactly ACC_WIDTH cycles)
  - Two restoring radix-2 dividers, x and y, run in parallel and share the divisor `area`. They produce one quotient bit per cycle, MSB first.
  - Partial remainders are ACC_WIDTH+1 bits wide.
  - The quotient is truncated to its low LOC_WIDTH bits. Centroids are bounded by image size, so no overflow flag is needed.
  - Go to OUT.
- **OUT**
  - `out_valid` = 1; `out_id`, `out_x`, `out_y`, `out_area` are held stable until `out_ready`.
  - On `out_valid && out_ready`: if `obj_id == last`, go to DONE; otherwise `obj_id++` and go to READ.
- **DONE** (1 cycle): `done` = 1, then return to IDLE. `obj_id` keeps its last value.
- Reset mid-scan: return to IDLE with reset values. No `done`, no partial record.
- `num_labels` changes during a scan are ignored; `last` is latched.

## Timing
- Table read latency: the data table answers `obj_id` combinationally within the same cycle, so the address registered on entry to READ is valid during READ.
- Reported object, with `out_ready` held high:
  - READ at cycle t.
  - `out_valid` high at t + ACC_WIDTH + 2, for one cycle.
  - Next READ at t + ACC_WIDTH + 3.
- Skipped object: 2 cycles (READ, CHECK).
- Backpressure: OUT holds for any number of cycles. Outputs must not change while `out_valid && !out_ready`.
- `done` follows the final handshake or final skip by exactly 1 cycle. With `num_labels <= 1`, `done` is at `start` + 1.
- `busy` rises the cycle after an accepted `start` and falls when DONE is left.

## Configuration
- `OBJ_SIZE_FILTER_EN`
  - Defined: objects with `0 < area < MIN_AREA` are skipped in CHECK (2 cycles, no record).
  - Undefined: the `MIN_AREA` comparison is not built, and every label with nonzero area is reported.
  - Area-0 labels (merged or unused) are skipped in both builds.

## Test plan
- `num_labels` = 2, label 1: area 4, x_acc 40, y_acc 20, `out_ready` = 1 → one record (id 1, x 10, y 5, area 4) with `out_valid` at READ + 34; `done` 1 cycle later.
- `num_labels` = 1, `start` → `done` pulse 1 cycle after `start`; no `out_valid`; `busy` low again after DONE.
- `num_labels` = 4, label 2 area 0, labels 1 and 3 area 3 (x_acc 10, y_acc 7) → records for ids 1 and 3 only, each x 3, y 2 (truncated).
- `OBJ_SIZE_FILTER_EN` with `MIN_AREA` 4: label 1 area 3, label 2 area 4 → only id 2 reported. Without the macro → both reported.
- `out_ready` low for 10 cycles during OUT → `out_valid` and all `out_*` fields stable for 10 cycles; `obj_id` unchanged; advances on the first ready cycle.
- Assert `reset_n` = 0 during DIV → next cycle IDLE, all outputs 0, no `done`. A subsequent `start` rescans from label 1 and reproduces the correct records.
